// File: rtl/div_ctrl.sv
// Runtime controller for a modulo-M clock divider with a valid/ready config port and an optional finite burst.
// Optional mid-run reload through shadow registers is compiled in with `define DIV_CTRL_RELOAD_EN.
module div_ctrl #(
    parameter int W     = 24,
    parameter int M_DEF = 12000000,
    parameter int CW    = 16
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_div,
    input  logic [CW-1:0] cfg_cnt,
    input  logic          start,
    input  logic          stop,
    output logic          clk_out,
    output logic          tick,
    output logic          done,
    output logic          busy
);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t        state, state_d;
    logic [W-1:0]  counter, counter_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] periods, periods_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          xfer;
    logic          wrap;
    logic          last_period;

`ifdef DIV_CTRL_RELOAD_EN
    logic [W-1:0]  shadow_div, shadow_div_d;
    logic [CW-1:0] shadow_cnt, shadow_cnt_d;
    logic          pend, pend_d;
`endif

    // A divisor below 2 would leave no room for both clk_out phases.
    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
        return (d < W'(2)) ? W'(2) : d;
    endfunction

    assign busy        = (state == RUN);
    assign wrap        = busy && (counter == div_q - W'(1));
    assign last_period = (cnt_q != '0) && (periods == cnt_q - CW'(1));
    assign tick        = wrap;
    assign done        = wrap && last_period;
    assign clk_out     = busy && (counter >= (div_q >> 1));

`ifdef DIV_CTRL_RELOAD_EN
    assign cfg_ready = 1'b1;
`else
    assign cfg_ready = (state == IDLE);
`endif

    assign xfer = cfg_valid && cfg_ready;

    always_comb begin
        state_d   = state;
        counter_d = counter;
        periods_d = periods;
        div_d     = div_q;
        cnt_d     = cnt_q;
`ifdef DIV_CTRL_RELOAD_EN
        shadow_div_d = shadow_div;
        shadow_cnt_d = shadow_cnt;
        pend_d       = pend;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
                    div_d = clamp_div(cfg_div);
                    cnt_d = cfg_cnt;
                end
                if (start && !stop) begin
                    state_d   = RUN;
                    counter_d = '0;
                    periods_d = '0;
                end
            end
            RUN: begin
                counter_d = wrap ? '0 : counter + W'(1);
                if (wrap) begin
                    periods_d = periods + CW'(1);
                end
`ifdef DIV_CTRL_RELOAD_EN
                // A transfer in the wrap cycle misses this boundary and waits for the next one.
                if (xfer) begin
                    shadow_div_d = clamp_div(cfg_div);
                    shadow_cnt_d = cfg_cnt;
                    pend_d       = 1'b1;
                end
                if (wrap && pend) begin
                    div_d     = shadow_div;
                    cnt_d     = shadow_cnt;
                    periods_d = '0;
                    if (!xfer) begin
                        pend_d = 1'b0;
                    end
                end
                // No later wrap exists once the burst ends, so a same-cycle offer lands directly.
                if (done && xfer) begin
                    div_d  = clamp_div(cfg_div);
                    cnt_d  = cfg_cnt;
                    pend_d = 1'b0;
                end
                if (stop) begin
                    pend_d = 1'b0;
                end
`endif
                if (stop || done) begin
                    state_d   = IDLE;
                    counter_d = '0;
                    periods_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            periods <= '0;
            div_q   <= W'(M_DEF);
            cnt_q   <= '0;
`ifdef DIV_CTRL_RELOAD_EN
            shadow_div <= '0;
            shadow_cnt <= '0;
            pend       <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            counter <= counter_d;
            periods <= periods_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
`ifdef DIV_CTRL_RELOAD_EN
            shadow_div <= shadow_div_d;
            shadow_cnt <= shadow_cnt_d;
            pend       <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed steps plus randomized runs against a period-arithmetic model.
module tb_div_ctrl;

    localparam int W     = 24;
    localparam int CW    = 16;
    localparam int M_DEF = 8;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  cfg_div = '0;
    logic [CW-1:0] cfg_cnt = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clk_out;
    logic          tick;
    logic          done;
    logic          busy;

    int checks = 0;
    int failures = 0;

    div_ctrl #(.W(W), .M_DEF(M_DEF), .CW(CW)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_cnt   (cfg_cnt),
        .start     (start),
        .stop      (stop),
        .clk_out   (clk_out),
        .tick      (tick),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " tick"}, tick, 1'b0);
        chk({tag, " done"}, done, 1'b0);
        chk({tag, " clk_out"}, clk_out, 1'b0);
        chk({tag, " cfg_ready"}, cfg_ready, 1'b1);
    endtask

    // Config and start offered together: the run must use the new values.
    task automatic start_run(input int div, input int cnt);
        cfg_valid = 1'b1;
        cfg_div   = W'(div);
        cfg_cnt   = CW'(cnt);
        start     = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic start_only();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    // Model: j counts cycles after the start edge; period length m, burst of n periods (0 = endless).
    task automatic expect_run(input int m, input int n, input int cycles, input string tag);
        for (int j = 1; j <= cycles; j++) begin
            bit active;
            bit exp_ready;
            active = (n == 0) || (j <= n * m);
`ifdef DIV_CTRL_RELOAD_EN
            exp_ready = 1'b1;
`else
            exp_ready = !active;
`endif
            chk($sformatf("%s j=%0d busy", tag, j), busy, active);
            chk($sformatf("%s j=%0d tick", tag, j), tick, active && (j % m == 0));
            chk($sformatf("%s j=%0d clk_out", tag, j), clk_out, active && (((j - 1) % m) >= m / 2));
            chk($sformatf("%s j=%0d done", tag, j), done, (n != 0) && (j == n * m));
            chk($sformatf("%s j=%0d cfg_ready", tag, j), cfg_ready, exp_ready);
            cyc();
        end
    endtask

    initial begin
        int div, cnt, m;

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk_idle("reset");

        // Continuous M=3
        start_run(3, 0);
        expect_run(3, 0, 12, "m3_cont");
        do_stop();
        chk_idle("m3_stop");

        // Burst M=4, two periods, then idle afterwards
        start_run(4, 2);
        expect_run(4, 2, 10, "m4_burst2");
        chk_idle("m4_after");

        // Divisors 0 and 1 clamp to 2
        start_run(0, 2);
        expect_run(2, 2, 6, "div0");
        start_run(1, 0);
        expect_run(2, 0, 6, "div1");
        do_stop();
        chk_idle("div1_stop");

        // Continuous M=5, stop in cycle 2 of the second period with a config offer alongside
        start_run(5, 0);
        expect_run(5, 0, 6, "m5_cont");
        stop      = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = W'(3);
        cfg_cnt   = CW'(1);
`ifndef DIV_CTRL_RELOAD_EN
        chk("m5 cfg_ready in run", cfg_ready, 1'b0);
`endif
        chk("m5 stop-cycle tick", tick, 1'b0);
        cyc();
        stop      = 1'b0;
        cfg_valid = 1'b0;
        chk_idle("m5_stopped");
        // The refused offer must not have changed the divisor
        start_only();
        expect_run(5, 0, 10, "m5_again");
        do_stop();
        chk_idle("m5_again_stop");

        // start together with stop in IDLE stays idle
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk_idle("start_stop");
        cyc();
        chk_idle("start_stop_2");

        // Reset mid-burst, then the default divisor governs the next run
        start_run(6, 3);
        expect_run(6, 3, 8, "m6_burst3");
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle("mid_reset");
        start_only();
        expect_run(M_DEF, 0, 2 * M_DEF + 1, "mdef");
        do_stop();
        chk_idle("mdef_stop");

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            div = int'($urandom_range(0, 9));
            cnt = int'($urandom_range(0, 3));
            m = (div < 2) ? 2 : div;
            start_run(div, cnt);
            if (cnt > 0) begin
                expect_run(m, cnt, m * cnt + 2, $sformatf("rnd%0d", r));
            end else begin
                expect_run(m, 0, 3 * m, $sformatf("rnd%0d", r));
                do_stop();
            end
            chk_idle($sformatf("rnd%0d_end", r));
        end

`ifdef DIV_CTRL_RELOAD_EN
        // Mid-period reload: current M=4 period finishes, then M=2 periods follow
        start_run(4, 0);
        expect_run(4, 0, 1, "reload_pre");
        cfg_valid = 1'b1;
        cfg_div   = W'(2);
        cfg_cnt   = CW'(0);
        chk("reload cfg_ready", cfg_ready, 1'b1);
        cyc();
        cfg_valid = 1'b0;
        for (int j = 3; j <= 12; j++) begin
            bit et, ec;
            if (j <= 4) begin
                et = (j == 4);
                ec = ((j - 1) % 4) >= 2;
            end else begin
                et = ((j - 4) % 2 == 0);
                ec = ((j - 5) % 2) >= 1;
            end
            chk($sformatf("reload j=%0d busy", j), busy, 1'b1);
            chk($sformatf("reload j=%0d tick", j), tick, et);
            chk($sformatf("reload j=%0d clk_out", j), clk_out, ec);
            chk($sformatf("reload j=%0d done", j), done, 1'b0);
            cyc();
        end
        do_stop();
        chk_idle("reload_stop");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
